// File: rtl/imem_responder.sv
// Instruction-memory responder: direct-mapped one-word-per-line read cache,
// write-through / no-allocate, fronting a req/ack backing-store bus.
//
// Handshakes: a request is taken only in IDLE when en=1; the requester then
// waits for the single-cycle data_valid pulse before presenting another one.
// On the backing side mem_req is held, with mem_addr/mem_we/mem_wdata stable,
// until mem_ack is sampled high while mem_req=1 (mem_ack in the same cycle
// mem_req rises is allowed); mem_req drops on the following cycle.
module imem_responder #(
  parameter int          LINES      = 16,
  parameter logic [31:0] BASE       = 32'h1000_2000,
  parameter int          SIZE_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        wr,
  input  logic        en,
  input  logic        inv,
  output logic        data_valid,
  output logic [31:0] data_out,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  dbg_state
);

  localparam int          IDX    = $clog2(LINES);
  localparam int          TW     = 30 - IDX;
  localparam logic [32:0] WIN_LO = {1'b0, BASE};
  localparam logic [32:0] WIN_HI = WIN_LO + 33'(SIZE_WORDS) * 33'd4;
  localparam logic [31:0] NOP    = 32'h7800_0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_FILL   = 3'd2,
    S_WRITE  = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [29:0]       word_q, word_d;
  logic              wr_q, wr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              dv_q, dv_d;
  logic              err_q, err_d;
  logic [31:0]       dout_q, dout_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       maddr_q, maddr_d;
  logic [31:0]       mwdata_q, mwdata_d;

  // Tag/data storage is deliberately left without reset; valid_q gates it.
  logic [TW-1:0]     tag_q  [LINES];
  logic [31:0]       data_q [LINES];

  logic [IDX-1:0]    idx;
  logic [TW-1:0]     tag;
  logic              hit;
  logic              in_win;
  logic [32:0]       addr_ext;
  logic              fill_we;
  logic              wr_upd;
  logic              ack_ok;

  assign idx      = word_q[IDX-1:0];
  assign tag      = word_q[29:IDX];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign addr_ext = {1'b0, addr};
  assign in_win   = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
  assign ack_ok   = mem_ack && req_q;

  assign data_valid = dv_q;
  assign data_out   = dout_q;
  assign err        = err_q;
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = maddr_q;
  assign mem_wdata  = mwdata_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    dv_d     = 1'b0;
    err_d    = 1'b0;
    dout_d   = dout_q;
    req_d    = req_q;
    we_d     = we_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    fill_we  = 1'b0;
    wr_upd   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          word_d  = addr[31:2];
          wr_d    = wr;
          wdata_d = data_in;
          state_d = in_win ? S_LOOKUP : S_ERR;
        end
      end
      S_LOOKUP: begin
        if (wr_q) begin
          req_d    = 1'b1;
          we_d     = 1'b1;
          maddr_d  = {word_q, 2'b00};
          mwdata_d = wdata_q;
          state_d  = S_WRITE;
        end else if (hit) begin
          dv_d    = 1'b1;
          dout_d  = data_q[idx];
          state_d = S_IDLE;
        end else begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          maddr_d = {word_q, 2'b00};
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (ack_ok) begin
          fill_we = 1'b1;
          dout_d  = mem_rdata;
          dv_d    = 1'b1;
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (ack_ok) begin
          wr_upd  = hit;
          dv_d    = 1'b1;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        dv_d    = 1'b1;
        err_d   = 1'b1;
        dout_d  = NOP;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Invalidate overrides a coincident fill, so the filled line stays invalid.
  always_comb begin
    valid_d = valid_q;
    if (inv) begin
      valid_d = '0;
    end else if (fill_we) begin
      valid_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      valid_q  <= '0;
      word_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
      dout_q   <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      word_q   <= word_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
      dout_q   <= dout_d;
      req_q    <= req_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= mem_rdata;
    end else if (wr_upd) begin
      data_q[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: backing-store model with configurable
// ack wait, bus monitor, and a response scoreboard queue.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h7800_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_in = '0;
  logic        wr = 1'b0;
  logic        en = 1'b0;
  logic        inv;
  logic        inv_tb = 1'b0;
  logic        inv_ack = 1'b0;
  logic        data_valid;
  logic [31:0] data_out;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [2:0]  dbg_state;

  assign inv = inv_tb | inv_ack;

  imem_responder dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .wr(wr),
    .en(en), .inv(inv), .data_valid(data_valid), .data_out(data_out),
    .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- backing store model ----------------
  logic [31:0] bs [logic [31:0]];
  int          ack_wait = 1;      // cycles mem_req is high, ack cycle included
  bit          spurious = 1'b0;
  bit          inv_on_ack = 1'b0;
  int          req_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
      inv_ack = 1'b0;
      req_cnt = 0;
    end else if (mem_req) begin
      req_cnt++;
      if (req_cnt >= ack_wait) begin
        mem_ack   = 1'b1;
        inv_ack   = inv_on_ack;
        mem_rdata = bs.exists(mem_addr) ? bs[mem_addr] : 32'h0;
        if (mem_we) bs[mem_addr] = mem_wdata;
      end else begin
        mem_ack   = 1'b0;
        inv_ack   = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      req_cnt   = 0;
      mem_ack   = spurious;
      inv_ack   = 1'b0;
      mem_rdata = $urandom;
    end
  end

  // ---------------- bus monitor ----------------
  int          rises = 0, hi = 0, unstable = 0, consec = 0;
  logic        req_prev = 1'b0, dv_prev = 1'b0;
  logic [31:0] obs_addr = '0, obs_wdata = '0;
  logic        obs_we = 1'b0;

  always @(negedge clk) begin
    if (mem_req && !req_prev) begin
      rises++;
      obs_addr  = mem_addr;
      obs_we    = mem_we;
      obs_wdata = mem_wdata;
    end else if (mem_req && (mem_addr !== obs_addr || mem_we !== obs_we ||
                             mem_wdata !== obs_wdata)) begin
      unstable++;
    end
    if (mem_req) hi++;
    if (data_valid && dv_prev) consec++;
    req_prev = mem_req;
    dv_prev  = data_valid;
  end

  // ---------------- scoreboard / driver ----------------
  logic [32:0] exp_q[$];
  logic [32:0] e;
  logic [31:0] last_exp = '0;
  int          passed = 0, total = 0;
  logic        obs_ok;
  logic [32:0] obs_resp;
  int          obs_lat;
  logic        obs_req_at_dv;

  // obs_lat counts the requester sampling edge: capture edge is 0.
  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [32:0] ex, input bit inv_lk);
    exp_q.push_back(ex);
    last_exp = ex[31:0];
    rises = 0; hi = 0; unstable = 0;
    @(negedge clk);
    addr = a; wr = w; data_in = d; en = 1'b1;
    @(negedge clk);
    en = 1'b0; addr = $urandom; wr = 1'($urandom); data_in = $urandom;
    if (inv_lk) inv_tb = 1'b1;
    obs_ok = 1'b0; obs_lat = 0; obs_resp = 'x; obs_req_at_dv = 1'bx;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      inv_tb = 1'b0;
      if (data_valid) begin
        obs_ok = 1'b1; obs_lat = i + 1; obs_resp = {err, data_out};
        obs_req_at_dv = mem_req;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({data_valid, err, mem_req, mem_we} !== 4'b0) $display("FAIL reset_flags got=%b exp=0000", {data_valid, err, mem_req, mem_we}); else passed++;
    total++; if (data_out !== 32'h0) $display("FAIL reset_data_out got=%h exp=0", data_out); else passed++;
    total++; if ({mem_addr, mem_wdata} !== 64'h0) $display("FAIL reset_mem_bus got=%h exp=0", {mem_addr, mem_wdata}); else passed++;
    total++; if (dbg_state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", dbg_state); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_read_miss();
    bs[32'h1000_2000] = 32'hDEAD_BEEF;
    ack_wait = 3;
    access(32'h1000_2000, 1'b0, 32'h0, {1'b0, 32'hDEAD_BEEF}, 1'b0);
    e = exp_q.pop_front();
    total++; if (!obs_ok || obs_resp !== e) $display("FAIL miss_resp got=%h exp=%h", obs_resp, e); else passed++;
    total++; if (rises !== 1 || hi !== 3) $display("FAIL miss_req got_rises=%0d got_hi=%0d exp=1/3", rises, hi); else passed++;
    total++; if (obs_addr !== 32'h1000_2000 || obs_we !== 1'b0) $display("FAIL miss_bus got=%h/%b exp=10002000/0", obs_addr, obs_we); else passed++;
    total++; if (obs_lat !== 5) $display("FAIL miss_latency got=%0d exp=5", obs_lat); else passed++;
    total++; if (obs_req_at_dv !== 1'b0 || unstable !== 0) $display("FAIL miss_req_drop got=%b/%0d exp=0/0", obs_req_at_dv, unstable); else passed++;
  endtask

  task automatic test_hit();
    access(32'h1000_2000, 1'b0, 32'h0, {1'b0, 32'hDEAD_BEEF}, 1'b0);
    e = exp_q.pop_front();
    total++; if (!obs_ok || obs_resp !== e) $display("FAIL hit_resp got=%h exp=%h", obs_resp, e); else passed++;
    total++; if (rises !== 0) $display("FAIL hit_no_req got=%0d exp=0", rises); else passed++;
    total++; if (obs_lat !== 2) $display("FAIL hit_latency got=%0d exp=2", obs_lat); else passed++;
  endtask

  task automatic test_conflict();
    bs[32'h1000_2040] = 32'h1111_1111;
    ack_wait = 2;
    access(32'h1000_2040, 1'b0, 32'h0, {1'b0, 32'h1111_1111}, 1'b0);
    e = exp_q.pop_front();
    total++; if (!obs_ok || obs_resp !== e || rises !== 1) $display("FAIL conflict_fill got=%h rises=%0d exp=%h rises=1", obs_resp, rises, e); else passed++;
    access(32'h1000_2000, 1'b0, 32'h0, {1'b0, 32'hDEAD_BEEF}, 1'b0);
    e = exp_q.pop_front();
    total++; if (!obs_ok || obs_resp !== e || rises !== 1) $display("FAIL conflict_evict got=%h rises=%0d exp=%h rises=1", obs_resp, rises, e); else passed++;
    access(32'h1000_2000, 1'b0, 32'h0, {1'b0, 32'hDEAD_BEEF}, 1'b0);
    e = exp_q.pop_front();
    total++; if (!obs_ok || obs_resp !== e || rises !== 0) $display("FAIL conflict_rehit got=%h rises=%0d exp=%h rises=0", obs_resp, rises, e); else passed++;
  endtask

  task automatic test_write();
    ack_wait = 1;
    access(32'h1000_2000, 1'b1, 32'h1234_5678, {1'b0, last_exp}, 1'b0);
    e = exp_q.pop_front();
    total++; if (!obs_ok || obs_resp !== e) $display("FAIL write_resp got=%h exp=%h", obs_resp, e); else passed++;
    total++; if (rises !== 1 || obs_we !== 1'b1 || obs_wdata !== 32'h1234_5678 || obs_addr !== 32'h1000_2000)
      $display("FAIL write_bus got=%0d/%b/%h/%h exp=1/1/12345678/10002000", rises, obs_we, obs_wdata, obs_addr); else passed++;
    total++; if (obs_lat !== 3) $display("FAIL write_zero_wait_latency got=%0d exp=3", obs_lat); else passed++;
    access(32'h1000_2000, 1'b0, 32'h0, {1'b0, 32'h1234_5678}, 1'b0);
    e = exp_q.pop_front();
    total++; if (!obs_ok || obs_resp !== e || rises !== 0) $display("FAIL write_hit_update got=%h rises=%0d exp=%h rises=0", obs_resp, rises, e); else passed++;
    access(32'h1000_2080, 1'b1, 32'hCAFE_F00D, {1'b0, last_exp}, 1'b0);
    e = exp_q.pop_front();
    total++; if (!obs_ok || obs_resp !== e || rises !== 1) $display("FAIL write_miss got=%h rises=%0d exp=%h rises=1", obs_resp, rises, e); else passed++;
    access(32'h1000_2080, 1'b0, 32'h0, {1'b0, 32'hCAFE_F00D}, 1'b0);
    e = exp_q.pop_front();
    total++; if (!obs_ok || obs_resp !== e || rises !== 1) $display("FAIL write_no_allocate got=%h rises=%0d exp=%h rises=1", obs_resp, rises, e); else passed++;
  endtask

  task automatic test_window();
    logic [31:0] oob [4];
    oob[0] = 32'h0000_0000; oob[1] = 32'h1001_2000;
    oob[2] = 32'h1000_1FFC; oob[3] = 32'hFFFF_FFFC;
    ack_wait = 2;
    for (int k = 0; k < 4; k++) begin
      access(oob[k], (k == 3), 32'h5555_AAAA, {1'b1, NOP}, 1'b0);
      e = exp_q.pop_front();
      total++; if (!obs_ok || obs_resp !== e || rises !== 0 || obs_lat !== 2)
        $display("FAIL window_err_%0d got=%h rises=%0d lat=%0d exp=%h rises=0 lat=2", k, obs_resp, rises, obs_lat, e); else passed++;
    end
    bs[32'h1001_1FFC] = 32'hA5A5_0001;
    access(32'h1001_1FFC, 1'b0, 32'h0, {1'b0, 32'hA5A5_0001}, 1'b0);
    e = exp_q.pop_front();
    total++; if (!obs_ok || obs_resp !== e || rises !== 1) $display("FAIL window_last_word got=%h rises=%0d exp=%h rises=1", obs_resp, rises, e); else passed++;
  endtask

  task automatic test_inv();
    bs[32'h1000_2004] = 32'h0BAD_F00D;
    ack_wait = 2;
    inv_on_ack = 1'b1;
    access(32'h1000_2004, 1'b0, 32'h0, {1'b0, 32'h0BAD_F00D}, 1'b0);
    inv_on_ack = 1'b0;
    e = exp_q.pop_front();
    total++; if (!obs_ok || obs_resp !== e || rises !== 1) $display("FAIL inv_fill_resp got=%h rises=%0d exp=%h rises=1", obs_resp, rises, e); else passed++;
    access(32'h1000_2004, 1'b0, 32'h0, {1'b0, 32'h0BAD_F00D}, 1'b0);
    e = exp_q.pop_front();
    total++; if (!obs_ok || obs_resp !== e || rises !== 1) $display("FAIL inv_fill_dropped got=%h rises=%0d exp=%h rises=1", obs_resp, rises, e); else passed++;
    access(32'h1000_2004, 1'b0, 32'h0, {1'b0, 32'h0BAD_F00D}, 1'b1);
    e = exp_q.pop_front();
    total++; if (!obs_ok || obs_resp !== e || rises !== 0) $display("FAIL inv_on_hit got=%h rises=%0d exp=%h rises=0", obs_resp, rises, e); else passed++;
    access(32'h1000_2004, 1'b0, 32'h0, {1'b0, 32'h0BAD_F00D}, 1'b0);
    e = exp_q.pop_front();
    total++; if (!obs_ok || obs_resp !== e || rises !== 1) $display("FAIL inv_after_hit got=%h rises=%0d exp=%h rises=1", obs_resp, rises, e); else passed++;
  endtask

  task automatic test_spurious();
    int bad = 0;
    spurious = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (data_valid || mem_req) bad++;
    end
    spurious = 1'b0;
    @(negedge clk);
    total++; if (bad !== 0 || dbg_state !== 3'd0) $display("FAIL spurious_ack got=%0d/%0d exp=0/0", bad, dbg_state); else passed++;
    access(32'h1000_2004, 1'b0, 32'h0, {1'b0, 32'h0BAD_F00D}, 1'b0);
    e = exp_q.pop_front();
    total++; if (!obs_ok || obs_resp !== e || rises !== 0) $display("FAIL spurious_then_hit got=%h rises=%0d exp=%h rises=0", obs_resp, rises, e); else passed++;
  endtask

  task automatic test_reset_mid_fill();
    int dv_seen = 0;
    bit got_req = 1'b0;
    bs[32'h1000_2008] = 32'h7777_8888;
    ack_wait = 20;
    @(negedge clk);
    addr = 32'h1000_2008; wr = 1'b0; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_req) begin got_req = 1'b1; break; end
    end
    total++; if (!got_req) $display("FAIL midfill_req_start got=0 exp=1"); else passed++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0 || dbg_state !== 3'd0) $display("FAIL midfill_async_abort got=%b/%0d exp=0/0", mem_req, dbg_state); else passed++;
    repeat (3) begin
      @(negedge clk);
      if (data_valid) dv_seen++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (data_valid) dv_seen++;
    end
    total++; if (dv_seen !== 0 || data_out !== 32'h0) $display("FAIL midfill_no_resp got=%0d/%h exp=0/0", dv_seen, data_out); else passed++;
    ack_wait = 1;
    access(32'h1000_2004, 1'b0, 32'h0, {1'b0, 32'h0BAD_F00D}, 1'b0);
    e = exp_q.pop_front();
    total++; if (!obs_ok || obs_resp !== e || rises !== 1) $display("FAIL midfill_valid_cleared got=%h rises=%0d exp=%h rises=1", obs_resp, rises, e); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pool [6];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] a, d;
    logic        w;
    int          errs = 0;
    pool[0] = 32'h1000_2000; pool[1] = 32'h1000_2010; pool[2] = 32'h1000_2040;
    pool[3] = 32'h1000_2050; pool[4] = 32'h1000_3000; pool[5] = 32'h2000_0000;
    for (int k = 0; k < 5; k++) begin
      d = $urandom;
      bs[pool[k]] = d;
      ref_mem[pool[k]] = d;
    end
    for (int n = 0; n < 24; n++) begin
      a = pool[$urandom_range(0, 5)];
      w = ($urandom_range(0, 3) == 0);
      d = $urandom;
      ack_wait = $urandom_range(1, 4);
      if (a == 32'h2000_0000) e = {1'b1, NOP};
      else if (w) begin e = {1'b0, last_exp}; ref_mem[a] = d; end
      else e = {1'b0, ref_mem[a]};
      access(a, w, d, e, 1'b0);
      e = exp_q.pop_front();
      if (!obs_ok || obs_resp !== e) begin
        errs++;
        $display("FAIL b2b_%0d addr=%h wr=%b got=%h exp=%h", n, a, w, obs_resp, e);
      end
    end
    total++; if (errs !== 0) $display("FAIL b2b_total got=%0d errors exp=0", errs); else passed++;
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_hit();
    test_conflict();
    test_write();
    test_window();
    test_inv();
    test_spurious();
    test_reset_mid_fill();
    test_back_to_back();
    repeat (2) @(negedge clk);
    total++; if (consec !== 0) $display("FAIL dv_consecutive got=%0d exp=0", consec); else passed++;
    total++; if (exp_q.size() !== 0) $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Responder end of the fetch-stage instruction memory interface: accepts word requests (addr, en, wr, data_in) and answers with data_valid/data_out.
- Holds a small direct-mapped, one-word-per-line read cache in front of a backing-store request/acknowledge bus to the external memory.
- Write-through, no-allocate on write miss.
- Addresses outside the instruction window get an error response carrying a NOP, so fetch never executes garbage.

Parameters:
- LINES, 16, number of cache lines; power of 2, minimum 2. IDX = log2(LINES).
- BASE, 32'h10002000, first byte address of the instruction window; word aligned.
- SIZE_WORDS, 16384, window size in 32-bit words (64 KiB).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- addr  in  32  request byte address; addr[1:0] ignored
- data_in  in  32  write data
- wr  in  1  1 = write request, 0 = read request
- en  in  1  request enable
- inv  in  1  invalidate all lines (pulse)
- data_valid  out  1  one-cycle response pulse
- data_out  out  32  read data; holds its last value between responses
- err  out  1  pulses with data_valid on an out-of-window request
- mem_req  out  1  backing-store request; held until mem_ack
- mem_we  out  1  backing-store write
- mem_addr  out  32  backing-store word-aligned byte address
- mem_wdata  out  32  backing-store write data
- mem_ack  in  1  backing-store completion; read data valid in the same cycle
- mem_rdata  in  32  backing-store read data

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all valid bits cleared.
  - data_valid=0, err=0, mem_req=0, mem_we=0.
  - data_out=0, mem_addr=0, mem_wdata=0.
  - Tag and data arrays are not reset.
- Address decode:
  - word = addr[31:2]; index = word[IDX-1:0]; tag = word[29:IDX].
  - In-window when BASE <= addr < BASE + 4*SIZE_WORDS (unsigned 32-bit compare; no overflow, upper bound computed in 33 bits).
- Request capture:
  - In IDLE with en=1, addr/wr/data_in are registered. In-window requests move to LOOKUP; out-of-window requests move to ERR.
  - In any other state, addr/en/wr/data_in are ignored. No queueing: the requester re-presents the request after data_valid.
- States:
  - IDLE: wait for en.
  - LOOKUP, read: on hit, data_out = line data, data_valid=1, back to IDLE. Total hit latency is 2 cycles from the capture edge to the data_valid edge.
  - LOOKUP, read miss: go to FILL; assert mem_req=1, mem_we=0, mem_addr = {word,2'b00}.
  - LOOKUP, write: go to WRITE; assert mem_req=1, mem_we=1, mem_wdata = data_in.
  - FILL: hold mem_req and mem_addr stable until mem_ack. On mem_ack: write line (tag, data, valid=1), data_out = mem_rdata, data_valid=1, back to IDLE. mem_req deasserts the cycle after the ack.
  - WRITE: hold until mem_ack. On mem_ack: if the line tag matches and is valid, update line data (no allocate on miss); data_valid=1; data_out unchanged; back to IDLE.
  - ERR: data_valid=1, err=1, data_out = 32'h78000000 (NOP opcode 01111, rest 0); back to IDLE. The backing store is never accessed.
- inv:
  - Clears all valid bits at the next edge, in any state.
  - If inv coincides with a FILL ack, the fill data is still returned on data_out, but the line is left invalid (inv wins).
  - If inv coincides with a hit in LOOKUP, the hit is still served with the pre-invalidate data.
- Backing-store protocol:
  - mem_ack is accepted only while mem_req=1.
  - A spurious mem_ack in any other state is ignored.
  - mem_ack in the same cycle mem_req rises (zero-wait memory) is legal and completes that cycle.
- Reset mid-operation (FILL/WRITE) aborts immediately: mem_req drops and no response is generated.
- Request/response pairing: data_valid is never asserted in two consecutive cycles, and there is at most one outstanding request.

Test Plan:
- Reset, then read 0x10002000 with the backing store returning 0xDEADBEEF after 3 cycles -> one mem_req read at 0x10002000, held 3 cycles; data_valid pulse with data_out=0xDEADBEEF; err=0.
- Re-read 0x10002000 -> no mem_req; data_valid 2 cycles after capture, data_out=0xDEADBEEF.
- Read 0x10002040 (LINES=16, same index as 0x10002000, different tag) -> miss, fill with 0x11111111; re-reading 0x10002000 then misses again (conflict eviction).
- Write 0x12345678 to the cached 0x10002000 -> mem_we=1 with mem_wdata=0x12345678; after ack a read of 0x10002000 hits and returns 0x12345678. Write to uncached 0x10002080 -> no allocate, so the next read misses.
- Read 0x00000000 and 0x10012000 (one past the end) -> data_valid, err=1, data_out=0x78000000, mem_req stays 0. Read 0x10011FFC -> in-window, normal fill.
- Assert inv during a FILL ack -> data returned, but the next read of the same address misses. Drop rst_n mid-FILL -> mem_req=0 asynchronously; no data_valid; the next access misses.
